usrclk_rst_sequencer: RTL and testbench



---
 rtl/usrclk_rst_sequencer.sv | 136 +++++++++++++
 tb/tb_usrclk_rst_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usrclk_rst_sequencer.sv
// Init-clock sequencer for the transceiver user-clock buffer: pulses buf_rst, waits for a
// stable usrclk_active, then releases the datapath. Optional USRCLK_LOSS_COUNT_EN adds loss_cnt.
module usrclk_rst_sequencer #(
    parameter int BUF_RST_CYCLES = 16,
    parameter int STABLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               soft_reset,
    input  logic                               usrclk_active,
    output logic                               buf_rst,
    output logic                               usrclk_rst,
    output logic                               ready,
    output logic                               fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
`ifdef USRCLK_LOSS_COUNT_EN
    ,
    output logic [15:0]                        loss_cnt
`endif
);
    localparam int RW      = $clog2(MAX_RETRIES + 1);
    localparam int MAX_AB  = (BUF_RST_CYCLES > STABLE_CYCLES) ? BUF_RST_CYCLES : STABLE_CYCLES;
    localparam int CNT_MAX = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_BUF_RST,
        S_WAIT_ACTIVE,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    (* ASYNC_REG = "TRUE" *) logic act_meta;
    (* ASYNC_REG = "TRUE" *) logic act_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_meta <= 1'b0;
            act_s    <= 1'b0;
        end else begin
            act_meta <= usrclk_active;
            act_s    <= act_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_BUF_RST;
            cnt        <= '0;
            retry_cnt  <= '0;
            buf_rst    <= 1'b1;
            usrclk_rst <= 1'b1;
            ready      <= 1'b0;
            fail       <= 1'b0;
`ifdef USRCLK_LOSS_COUNT_EN
            loss_cnt   <= '0;
`endif
        end else begin
            // Outputs follow the state register one cycle later; fail drops with the restart itself.
            buf_rst    <= (state == S_BUF_RST);
            usrclk_rst <= (state != S_RUN);
            ready      <= (state == S_RUN);
            fail       <= (state == S_FAIL) && !soft_reset;

            if (soft_reset) begin
                state     <= S_BUF_RST;
                cnt       <= '0;
                retry_cnt <= '0;
            end else begin
                case (state)
                    S_BUF_RST: begin
                        if (cnt == CW'(BUF_RST_CYCLES - 1)) begin
                            state <= S_WAIT_ACTIVE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_WAIT_ACTIVE: begin
                        // A clock showing up on the final timeout cycle still counts as success.
                        if (act_s) begin
                            state <= S_STABLE;
                            cnt   <= CW'(1);
                        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                            cnt <= '0;
                            if (retry_cnt < RW'(MAX_RETRIES)) begin
                                retry_cnt <= retry_cnt + 1'b1;
                                state     <= S_BUF_RST;
                            end else begin
                                state <= S_FAIL;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_STABLE: begin
                        if (!act_s) begin
                            state <= S_WAIT_ACTIVE;
                            cnt   <= '0;
                        end else if (cnt == CW'(STABLE_CYCLES)) begin
                            state     <= S_RUN;
                            cnt       <= '0;
                            retry_cnt <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (!act_s) begin
                            state <= S_BUF_RST;
                            cnt   <= '0;
`ifdef USRCLK_LOSS_COUNT_EN
                            if (loss_cnt != 16'hFFFF)
                                loss_cnt <= loss_cnt + 16'd1;
`endif
                        end
                    end
                    S_FAIL: begin
                        state <= S_FAIL;
                    end
                    default: begin
                        state <= S_BUF_RST;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usrclk_rst_sequencer.sv
// Scoreboard bench for usrclk_rst_sequencer (default parameters); loss_cnt checked when
// USRCLK_LOSS_COUNT_EN is defined.
module tb_usrclk_rst_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       soft_reset = 1'b0;
    logic       usrclk_active = 1'b0;
    logic       buf_rst, usrclk_rst, ready, fail;
    logic [1:0] retry_cnt;
`ifdef USRCLK_LOSS_COUNT_EN
    logic [15:0] loss_cnt;
`endif

    usrclk_rst_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .soft_reset    (soft_reset),
        .usrclk_active (usrclk_active),
        .buf_rst       (buf_rst),
        .usrclk_rst    (usrclk_rst),
        .ready         (ready),
        .fail          (fail),
        .retry_cnt     (retry_cnt)
`ifdef USRCLK_LOSS_COUNT_EN
        ,
        .loss_cnt      (loss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // obs = {buf_rst, usrclk_rst, ready, fail, retry_cnt}
    logic [5:0] obs;
    assign obs = {buf_rst, usrclk_rst, ready, fail, retry_cnt};

    typedef struct {
        int          step;
        logic [5:0]  o;
        logic [15:0] loss;
        string       nm;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   nchk = 0;
    int   nerr = 0;

    task test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nchk++;
        if (obs !== 6'b110000) begin
            nerr++;
            $display("FAIL reset_values: got %b expected %b", obs, 6'b110000);
        end
    endtask

    // Release rst; active first sampled at edge 20, ready expected after edge 87.
    task test_bringup;
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 1; i <= 95; i++)
            sb.push_back('{i, {i <= 16, i < 87, i >= 87, 1'b0, 2'd0}, 16'd0, "bringup"});
        for (int i = 1; i <= 95; i++) begin
            @(posedge clk); #1;
            if (i == 19) usrclk_active = 1'b1;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].step == i) begin
                e = sb.pop_front();
                nchk++;
                if (obs !== e.o) begin nerr++; $display("FAIL %s step %0d: got %b expected %b", e.nm, i, obs, e.o); end
`ifdef USRCLK_LOSS_COUNT_EN
                nchk++;
                if (loss_cnt !== e.loss) begin nerr++; $display("FAIL %s_loss step %0d: got %0d expected %0d", e.nm, i, loss_cnt, e.loss); end
`endif
            end
        end
        nchk++;
        if (sb.size() != 0) begin nerr++; $display("FAIL bringup_leftover: got %0d expected 0", sb.size()); sb.delete(); end
    endtask

    // Drop active in RUN: ready falls after edge 4, buf_rst 4..19, re-bring-up ready at 92.
    task test_clock_loss;
        @(posedge clk); #1; usrclk_active = 1'b0;
        for (int i = 1; i <= 95; i++)
            sb.push_back('{i, {i >= 4 && i <= 19, i >= 4 && i < 92, i <= 3 || i >= 92, 1'b0, 2'd0},
                           (i >= 3) ? 16'd1 : 16'd0, "clock_loss"});
        for (int i = 1; i <= 95; i++) begin
            @(posedge clk); #1;
            if (i == 24) usrclk_active = 1'b1;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].step == i) begin
                e = sb.pop_front();
                nchk++;
                if (obs !== e.o) begin nerr++; $display("FAIL %s step %0d: got %b expected %b", e.nm, i, obs, e.o); end
`ifdef USRCLK_LOSS_COUNT_EN
                nchk++;
                if (loss_cnt !== e.loss) begin nerr++; $display("FAIL %s_loss step %0d: got %0d expected %0d", e.nm, i, loss_cnt, e.loss); end
`endif
            end
        end
        nchk++;
        if (sb.size() != 0) begin nerr++; $display("FAIL clock_loss_leftover: got %0d expected 0", sb.size()); sb.delete(); end
    endtask

    // Restart from RUN, then a 4-cycle dropout mid-STABLE; active re-sampled high at edge 45.
    task test_glitch;
        @(posedge clk); #1; soft_reset = 1'b1;
        for (int i = 1; i <= 115; i++)
            sb.push_back('{i, {i >= 2 && i <= 17, !(i <= 1 || i >= 112), i <= 1 || i >= 112, 1'b0, 2'd0},
                           16'd1, "glitch"});
        for (int i = 1; i <= 115; i++) begin
            @(posedge clk); #1;
            if (i == 1)  soft_reset = 1'b0;
            if (i == 40) usrclk_active = 1'b0;
            if (i == 44) usrclk_active = 1'b1;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].step == i) begin
                e = sb.pop_front();
                nchk++;
                if (obs !== e.o) begin nerr++; $display("FAIL %s step %0d: got %b expected %b", e.nm, i, obs, e.o); end
`ifdef USRCLK_LOSS_COUNT_EN
                nchk++;
                if (loss_cnt !== e.loss) begin nerr++; $display("FAIL %s_loss step %0d: got %0d expected %0d", e.nm, i, loss_cnt, e.loss); end
`endif
            end
        end
        nchk++;
        if (sb.size() != 0) begin nerr++; $display("FAIL glitch_leftover: got %0d expected 0", sb.size()); sb.delete(); end
    endtask

    // soft_reset from RUN, then again mid-STABLE at edge 41.
    task test_soft_reset_stable;
        @(posedge clk); #1; soft_reset = 1'b1;
        for (int i = 1; i <= 126; i++)
            sb.push_back('{i, {(i >= 2 && i <= 17) || (i >= 42 && i <= 57), !(i <= 1 || i >= 123),
                               i <= 1 || i >= 123, 1'b0, 2'd0}, 16'd1, "soft_stable"});
        for (int i = 1; i <= 126; i++) begin
            @(posedge clk); #1;
            if (i == 1 || i == 41) soft_reset = 1'b0;
            if (i == 40) soft_reset = 1'b1;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].step == i) begin
                e = sb.pop_front();
                nchk++;
                if (obs !== e.o) begin nerr++; $display("FAIL %s step %0d: got %b expected %b", e.nm, i, obs, e.o); end
`ifdef USRCLK_LOSS_COUNT_EN
                nchk++;
                if (loss_cnt !== e.loss) begin nerr++; $display("FAIL %s_loss step %0d: got %0d expected %0d", e.nm, i, loss_cnt, e.loss); end
`endif
            end
        end
        nchk++;
        if (sb.size() != 0) begin nerr++; $display("FAIL soft_stable_leftover: got %0d expected 0", sb.size()); sb.delete(); end
    endtask

    // Clock loss with no recovery: attempts start at edges 3, 4115, 8227, 12339; FAIL after 16452.
    task test_timeout;
        logic [1:0] r;
        logic       b;
        @(posedge clk); #1; usrclk_active = 1'b0;
        for (int i = 1; i <= 16500; i++) begin
            r = (i < 4115) ? 2'd0 : (i < 8227) ? 2'd1 : (i < 12339) ? 2'd2 : 2'd3;
            b = (i >= 4 && i <= 19) || (i >= 4116 && i <= 4131) ||
                (i >= 8228 && i <= 8243) || (i >= 12340 && i <= 12355);
            sb.push_back('{i, {b, i >= 4, i <= 3, i >= 16452, r}, (i >= 3) ? 16'd2 : 16'd1, "timeout"});
        end
        for (int i = 1; i <= 16500; i++) begin
            @(posedge clk); #1;
            if (i == 16460) usrclk_active = 1'b1;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].step == i) begin
                e = sb.pop_front();
                nchk++;
                if (obs !== e.o) begin nerr++; $display("FAIL %s step %0d: got %b expected %b", e.nm, i, obs, e.o); end
`ifdef USRCLK_LOSS_COUNT_EN
                nchk++;
                if (loss_cnt !== e.loss) begin nerr++; $display("FAIL %s_loss step %0d: got %0d expected %0d", e.nm, i, loss_cnt, e.loss); end
`endif
            end
        end
        nchk++;
        if (sb.size() != 0) begin nerr++; $display("FAIL timeout_leftover: got %0d expected 0", sb.size()); sb.delete(); end
    endtask

    task test_soft_reset_fail;
        @(posedge clk); #1; soft_reset = 1'b1;
        for (int i = 1; i <= 90; i++)
            sb.push_back('{i, {i >= 2 && i <= 17, i < 83, i >= 83, 1'b0, 2'd0}, 16'd2, "soft_fail"});
        for (int i = 1; i <= 90; i++) begin
            @(posedge clk); #1;
            if (i == 1) soft_reset = 1'b0;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].step == i) begin
                e = sb.pop_front();
                nchk++;
                if (obs !== e.o) begin nerr++; $display("FAIL %s step %0d: got %b expected %b", e.nm, i, obs, e.o); end
`ifdef USRCLK_LOSS_COUNT_EN
                nchk++;
                if (loss_cnt !== e.loss) begin nerr++; $display("FAIL %s_loss step %0d: got %0d expected %0d", e.nm, i, loss_cnt, e.loss); end
`endif
            end
        end
        nchk++;
        if (sb.size() != 0) begin nerr++; $display("FAIL soft_fail_leftover: got %0d expected 0", sb.size()); sb.delete(); end
    endtask

    // rst between edges in RUN must act at once; restart with active held high, ready after edge 82.
    task test_async_reset;
        @(posedge clk); #3; rst = 1'b1;
        #1;
        nchk++;
        if (obs !== 6'b110000) begin nerr++; $display("FAIL async_reset: got %b expected %b", obs, 6'b110000); end
`ifdef USRCLK_LOSS_COUNT_EN
        nchk++;
        if (loss_cnt !== 16'd0) begin nerr++; $display("FAIL async_reset_loss: got %0d expected 0", loss_cnt); end
`endif
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 1; i <= 85; i++)
            sb.push_back('{i, {i <= 16, i < 82, i >= 82, 1'b0, 2'd0}, 16'd0, "after_reset"});
        for (int i = 1; i <= 85; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].step == i) begin
                e = sb.pop_front();
                nchk++;
                if (obs !== e.o) begin nerr++; $display("FAIL %s step %0d: got %b expected %b", e.nm, i, obs, e.o); end
`ifdef USRCLK_LOSS_COUNT_EN
                nchk++;
                if (loss_cnt !== e.loss) begin nerr++; $display("FAIL %s_loss step %0d: got %0d expected %0d", e.nm, i, loss_cnt, e.loss); end
`endif
            end
        end
        nchk++;
        if (sb.size() != 0) begin nerr++; $display("FAIL after_reset_leftover: got %0d expected 0", sb.size()); sb.delete(); end
    endtask

    initial begin
        test_reset;
        test_bringup;
        test_clock_loss;
        test_glitch;
        test_soft_reset_stable;
        test_timeout;
        test_soft_reset_fail;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
